// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//
// Bundle between the decoder/datapath side and the program-counter sequencer.
//
// Decoder/datapath -> sequencer:
//   stall    memory not ready, freeze sequencer state
//   pc_mux   next-PC select (0 ADD, 1 WREG, 2 LIT, 3 SAVE)
//   op_hi    opcode[4:1], qualifies skip and wfi/rfi
//   skip     ALU skip-condition result
//   lit      instruction literal / jump target
//   wreg     W register contents
//   irq      interrupt request (level or single-cycle pulse)
//
// Sequencer -> decoder/datapath:
//   pc          address of the current instruction
//   save_pc     interrupt return address
//   in_isr      interrupt handler active
//   waiting     sequencer parked in the wfi wait state
//   irq_pending latched interrupt request
//   squash      current instruction must not commit (combinational)
//
// The "master" modport is the decoder/datapath view, "slave" the sequencer.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
);
    logic              stall;
    logic [1:0]        pc_mux;
    logic [3:0]        op_hi;
    logic              skip;
    logic [PC_W-1:0]   lit;
    logic [DATA_W-1:0] wreg;
    logic              irq;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   save_pc;
    logic              in_isr;
    logic              waiting;
    logic              irq_pending;
    logic              squash;

    modport master (
        output stall, pc_mux, op_hi, skip, lit, wreg, irq,
        input  pc, save_pc, in_isr, waiting, irq_pending, squash
    );

    modport slave (
        input  stall, pc_mux, op_hi, skip, lit, wreg, irq,
        output pc, save_pc, in_isr, waiting, irq_pending, squash
    );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter and control-flow stage behind the instruction decoder.
// Computes the fetch address of the next instruction from the decoder's
// pc_mux select, the skip flag, the literal and W, and implements a
// single-level interrupt: pending latch, saved return PC, wfi wait state and
// rfi return. squash tells the datapath to drop the writes of an instruction
// that is preempted by an interrupt take or that sits in the wait state.
//
// Ports:
//   mem_clock  sole clock, rising edge
//   reset      synchronous, active-high
//   bus        pc_sequencer_if.slave (see interface header for signals)
//
// Parameters:
//   PC_W       program-counter width
//   DATA_W     W register width
//   RESET_VEC  PC after reset
//   INT_VEC    interrupt entry address
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int          PC_W      = 8,
    parameter int          DATA_W    = 8,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned INT_VEC   = 1
) (
    input  logic               mem_clock,
    input  logic               reset,
    pc_sequencer_if.slave      bus
);

    localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0] INT_PC   = PC_W'(INT_VEC);

    localparam logic [1:0] MUX_ADD  = 2'd0;
    localparam logic [1:0] MUX_WREG = 2'd1;
    localparam logic [1:0] MUX_LIT  = 2'd2;
    localparam logic [1:0] MUX_SAVE = 2'd3;

    localparam logic [3:0] OP_SKIP_A = 4'hA;
    localparam logic [3:0] OP_SKIP_B = 4'hB;
    localparam logic [3:0] OP_WFI    = 4'hE;
    localparam logic [3:0] OP_RFI    = 4'hF;

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] save_pc_q, save_pc_d;
    logic            in_isr_q, in_isr_d;
    logic            irq_pending_q, irq_pending_d;

    logic [PC_W-1:0] pc_inc1;
    logic [PC_W-1:0] pc_inc2;
    logic [PC_W-1:0] wreg_pc;
    logic            skip_op;
    logic            take;

    // W is zero-extended or truncated to the PC width; padding on the left
    // and slicing the low bits handles both DATA_W < PC_W and DATA_W >= PC_W.
    logic [PC_W+DATA_W-1:0] wreg_pad;
    assign wreg_pad = {{PC_W{1'b0}}, bus.wreg};
    assign wreg_pc  = wreg_pad[PC_W-1:0];

    // PC arithmetic wraps naturally at PC_W bits.
    assign pc_inc1 = pc_q + PC_W'(1);
    assign pc_inc2 = pc_q + PC_W'(2);

    // Only the two skip-class opcodes may turn an ADD into a double step.
    assign skip_op = (bus.op_hi == OP_SKIP_A) || (bus.op_hi == OP_SKIP_B);

    // Interrupts are single level: a request arriving inside the handler
    // stays latched until rfi clears in_isr.
    assign take = irq_pending_q && !in_isr_q && !bus.stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        save_pc_d     = save_pc_q;
        in_isr_d      = in_isr_q;
        irq_pending_d = irq_pending_q;

        // A new request wins over the clear caused by a take on the same edge,
        // and is captured even while stalled.
        if (bus.irq) begin
            irq_pending_d = 1'b1;
        end else if (take) begin
            irq_pending_d = 1'b0;
        end

        if (take) begin
            // From RUN the preempted instruction re-executes on return; from
            // WAIT the return lands on the instruction after the wfi.
            save_pc_d = (state_q == ST_WAIT) ? pc_inc1 : pc_q;
            pc_d      = INT_PC;
            in_isr_d  = 1'b1;
            state_d   = ST_RUN;
        end else if (!bus.stall && (state_q == ST_RUN)) begin
            case (bus.pc_mux)
                MUX_ADD:  pc_d = (skip_op && bus.skip) ? pc_inc2 : pc_inc1;
                MUX_WREG: pc_d = wreg_pc;
                MUX_LIT:  pc_d = bus.lit;
                MUX_SAVE: begin
                    if ((bus.op_hi == OP_WFI) && !in_isr_q) begin
                        // Park on the wfi address until an interrupt arrives.
                        state_d = ST_WAIT;
                    end else if ((bus.op_hi == OP_RFI) && in_isr_q) begin
                        pc_d     = save_pc_q;
                        in_isr_d = 1'b0;
                    end else begin
                        // wfi inside the handler and rfi outside it are NOPs.
                        pc_d = pc_inc1;
                    end
                end
                default:  pc_d = pc_inc1;
            endcase
        end
    end

    always_ff @(posedge mem_clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            save_pc_q     <= '0;
            in_isr_q      <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            save_pc_q     <= save_pc_d;
            in_isr_q      <= in_isr_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.save_pc     = save_pc_q;
    assign bus.in_isr      = in_isr_q;
    assign bus.waiting     = (state_q == ST_WAIT);
    assign bus.irq_pending = irq_pending_q;

    // Nothing commits while stalled, so squash is forced low then.
    assign bus.squash = !bus.stall && (take || (state_q == ST_WAIT));

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed walk through the main control-flow and interrupt scenarios, then a
// long randomized run, all compared against a behavioural model of the
// sequencer kept in plain integer variables.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int PC_W   = 8;
    localparam int DATA_W = 8;
    localparam int RESET_VEC = 0;
    localparam int INT_VEC   = 1;
    localparam int PC_MOD    = 1 << PC_W;

    logic clk;
    logic rst;

    pc_sequencer_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

    pc_sequencer #(
        .PC_W      (PC_W),
        .DATA_W    (DATA_W),
        .RESET_VEC (RESET_VEC),
        .INT_VEC   (INT_VEC)
    ) dut (
        .mem_clock (clk),
        .reset     (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int m_pc   = 0;
    int m_save = 0;
    bit m_isr  = 0;
    bit m_wait = 0;
    bit m_pend = 0;

    logic sq_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    // One clock edge of the architecture as described in words: reset wins,
    // stall freezes everything except the pending latch, an interrupt take
    // beats the instruction, and the instruction only runs outside WAIT.
    task automatic model_step(input bit r, input bit s, input bit q,
                              input int mux, input int op, input int sk,
                              input int lt, input int wr);
        bit take;
        if (r) begin
            m_pc = RESET_VEC; m_save = 0; m_isr = 0; m_wait = 0; m_pend = 0;
            return;
        end
        take = m_pend && !m_isr && !s;
        if (take) begin
            m_save = m_wait ? wrap(m_pc + 1) : m_pc;
            m_pc   = INT_VEC;
            m_isr  = 1;
            m_wait = 0;
        end else if (!s && !m_wait) begin
            case (mux)
                0: m_pc = wrap(m_pc + ((((op == 10) || (op == 11)) && (sk != 0)) ? 2 : 1));
                1: m_pc = wrap(wr);
                2: m_pc = wrap(lt);
                default: begin
                    if (op == 14 && !m_isr) begin
                        m_wait = 1;
                    end else if (op == 15 && m_isr) begin
                        m_pc  = m_save;
                        m_isr = 0;
                    end else begin
                        m_pc = wrap(m_pc + 1);
                    end
                end
            endcase
        end
        if (q) m_pend = 1;
        else if (take) m_pend = 0;
    endtask

    // Present one instruction for one cycle, check squash before the edge
    // and every registered output after it.
    task automatic cyc(input bit r, input bit s, input bit q,
                       input int mux, input int op, input int sk,
                       input int lt, input int wr);
        bit exp_sq;
        rst        = r;
        bus.stall  = s;
        bus.irq    = q;
        bus.pc_mux = 2'(mux);
        bus.op_hi  = 4'(op);
        bus.skip   = (sk != 0);
        bus.lit    = PC_W'(lt);
        bus.wreg   = DATA_W'(wr);
        @(negedge clk);
        exp_sq  = !s && ((m_pend && !m_isr) || m_wait);
        sq_seen = bus.squash;
        if (!r) chk("squash", 32'(bus.squash), 32'(exp_sq));
        @(posedge clk);
        model_step(r, s, q, mux, op, sk, lt, wr);
        #1;
        chk("pc",          32'(bus.pc),          32'(m_pc));
        chk("save_pc",     32'(bus.save_pc),     32'(m_save));
        chk("in_isr",      32'(bus.in_isr),      32'(m_isr));
        chk("waiting",     32'(bus.waiting),     32'(m_wait));
        chk("irq_pending", 32'(bus.irq_pending), 32'(m_pend));
    endtask

    task automatic add(input int op = 0, input int sk = 0, input bit q = 0);
        cyc(0, 0, q, 0, op, sk, 0, 0);
    endtask
    task automatic jmp(input int t);  cyc(0, 0, 0, 2, 0, 0, t, 0); endtask
    task automatic wfi();             cyc(0, 0, 0, 3, 14, 0, 0, 0); endtask
    task automatic rfi();             cyc(0, 0, 0, 3, 15, 0, 0, 0); endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0; bus.irq = 1'b0; bus.pc_mux = 2'd0; bus.op_hi = 4'd0;
        bus.skip = 1'b0; bus.lit = '0; bus.wreg = '0;
        @(posedge clk); #1;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_squash", 32'(bus.squash), 32'h0);

        // Sequential ADDs
        for (int i = 0; i < 6; i++) begin
            chk("seq_pc", 32'(bus.pc), 32'(i));
            add();
        end

        // Wrap and skip behaviour
        jmp(8'hFF); add();          chk("wrap_inc1", 32'(bus.pc), 32'h00);
        jmp(8'hFE); add(10, 1);     chk("wrap_skip", 32'(bus.pc), 32'h00);
        add(11, 1);                 chk("skip_b",    32'(bus.pc), 32'h02);
        add(8, 1);                  chk("noskip_op8", 32'(bus.pc), 32'h03);
        add(10, 0);                 chk("skip_false", 32'(bus.pc), 32'h04);

        // LIT, WREG, stall
        jmp(8'h40);                 chk("lit", 32'(bus.pc), 32'h40);
        cyc(0, 0, 0, 1, 0, 0, 0, 8'h23); chk("wreg", 32'(bus.pc), 32'h23);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 2, 0, 0, 8'h99, 0);
            chk("stall_hold", 32'(bus.pc), 32'h23);
        end
        add();                      chk("after_stall", 32'(bus.pc), 32'h24);

        // Interrupt from RUN
        jmp(8'h10);
        add(0, 0, 1);
        chk("irq_pend", 32'(bus.irq_pending), 32'h1);
        chk("irq_pc1",  32'(bus.pc), 32'h11);
        add();
        chk("take_squash", 32'(sq_seen), 32'h1);
        chk("take_save",   32'(bus.save_pc), 32'h11);
        chk("take_pc",     32'(bus.pc), 32'h01);
        chk("take_isr",    32'(bus.in_isr), 32'h1);
        add(); add();
        rfi();
        chk("rfi_pc",  32'(bus.pc), 32'h11);
        chk("rfi_isr", 32'(bus.in_isr), 32'h0);

        // wfi and wake-up
        jmp(8'h20);
        wfi();
        for (int i = 0; i < 5; i++) begin
            add();
            chk("wait_squash", 32'(sq_seen), 32'h1);
            chk("wait_pc",     32'(bus.pc), 32'h20);
            chk("wait_flag",   32'(bus.waiting), 32'h1);
        end
        add(0, 0, 1);
        chk("wait_irq_pc", 32'(bus.pc), 32'h20);
        add();
        chk("wake_pc",   32'(bus.pc), 32'h01);
        chk("wake_save", 32'(bus.save_pc), 32'h21);
        rfi();
        chk("wake_rfi", 32'(bus.pc), 32'h21);

        // Nested request held until after rfi
        jmp(8'h2F);
        add(0, 0, 1);
        add();
        chk("nest_save0", 32'(bus.save_pc), 32'h30);
        add(0, 0, 1);
        add();
        chk("nest_hold_pend", 32'(bus.irq_pending), 32'h1);
        chk("nest_hold_pc",   32'(bus.pc), 32'h03);
        rfi();
        chk("nest_rfi_pc", 32'(bus.pc), 32'h30);
        add();
        chk("nest_squash", 32'(sq_seen), 32'h1);
        chk("nest_save",   32'(bus.save_pc), 32'h30);
        chk("nest_pc",     32'(bus.pc), 32'h01);
        rfi();

        // Reset in WAIT with a pending request
        jmp(8'h50);
        wfi();
        add(0, 0, 1);
        chk("pre_rst_wait", 32'(bus.waiting), 32'h1);
        chk("pre_rst_pend", 32'(bus.irq_pending), 32'h1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("wrst_pc",   32'(bus.pc), 32'h0);
        chk("wrst_wait", 32'(bus.waiting), 32'h0);
        chk("wrst_isr",  32'(bus.in_isr), 32'h0);
        chk("wrst_pend", 32'(bus.irq_pending), 32'h0);

        // NOP forms of rfi and wfi
        rfi();
        chk("rfi_nop", 32'(bus.pc), 32'h01);
        add(0, 0, 1);
        add();
        wfi();
        chk("wfi_nop_pc",   32'(bus.pc), 32'h02);
        chk("wfi_nop_wait", 32'(bus.waiting), 32'h0);
        rfi();

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            bit r, s, q;
            int mux, op, sk, lt, wr;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 7) == 0);
            q   = ($urandom_range(0, 11) == 0);
            mux = $urandom_range(0, 3);
            op  = $urandom_range(0, 15);
            if (mux == 3) op = 14 + $urandom_range(0, 1);
            else if (mux == 0 && $urandom_range(0, 1) == 1) op = 10 + $urandom_range(0, 1);
            sk  = $urandom_range(0, 1);
            lt  = $urandom_range(0, PC_MOD - 1);
            wr  = $urandom_range(0, (1 << DATA_W) - 1);
            cyc(r, s, q, mux, op, sk, lt, wr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
